// File: rtl/data_memory_if.sv
// Bus bundle for data_memory: one write request channel, one read request channel
// and the registered read data returned to the MEM stage.
interface data_memory_if #(
   parameter int unsigned NB_DATA_BUS = 32,
   parameter int unsigned NB_ADDRESS  = 6
);
   logic [NB_ADDRESS-1:0]  i_r_addr;
   logic                   i_r_en;
   logic [1:0]             i_r_addressing;
   logic [NB_ADDRESS-1:0]  i_w_addr;
   logic [NB_DATA_BUS-1:0] i_w_data;
   logic                   i_w_en;
   logic [1:0]             i_w_addressing;
   logic [NB_DATA_BUS-1:0] o_r_data;

   modport master (
      output i_r_addr, i_r_en, i_r_addressing,
      output i_w_addr, i_w_data, i_w_en, i_w_addressing,
      input  o_r_data
   );

   modport slave (
      input  i_r_addr, i_r_en, i_r_addressing,
      input  i_w_addr, i_w_data, i_w_en, i_w_addressing,
      output o_r_data
   );
endinterface

// File: rtl/data_memory.sv
// Byte-organised little-endian data memory: synchronous word/half/byte writes,
// registered 1-cycle reads, wrapping unaligned addressing.
module data_memory #(
   parameter int unsigned NB_DATA_BUS = 32,
   parameter int unsigned NB_DATA     = 8,
   parameter int unsigned NB_ADDRESS  = 6
) (
   input logic          i_clk,
   input logic          i_rst_n,
   data_memory_if.slave bus
);
   localparam int unsigned NBYTES = NB_DATA_BUS / NB_DATA;
   localparam int unsigned DEPTH  = 2 ** NB_ADDRESS;

   logic [NB_DATA-1:0]     mem [DEPTH];
   logic [NBYTES-1:0]      w_mask;
   logic [NBYTES-1:0]      r_mask;
   logic [NB_ADDRESS-1:0]  w_idx [NBYTES];
   logic [NB_ADDRESS-1:0]  r_idx [NBYTES];
   logic [NB_DATA_BUS-1:0] rd_word;

   // Size decode to a byte-lane mask; reserved 2'b10 falls through to word.
   always_comb begin
      w_mask = '1;
      r_mask = '1;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         case (bus.i_w_addressing)
            2'b01:   w_mask[k] = (k < NBYTES / 2);
            2'b11:   w_mask[k] = (k == 0);
            default: w_mask[k] = 1'b1;
         endcase
         case (bus.i_r_addressing)
            2'b01:   r_mask[k] = (k < NBYTES / 2);
            2'b11:   r_mask[k] = (k == 0);
            default: r_mask[k] = 1'b1;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         w_idx[k] = bus.i_w_addr + NB_ADDRESS'(k);
         r_idx[k] = bus.i_r_addr + NB_ADDRESS'(k);
         if (r_mask[k])
            rd_word[k*NB_DATA +: NB_DATA] = mem[r_idx[k]];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned a = 0; a < DEPTH; a++)
            mem[a] <= '0;
      end else if (bus.i_w_en) begin
         for (int unsigned k = 0; k < NBYTES; k++)
            if (w_mask[k])
               mem[w_idx[k]] <= bus.i_w_data[k*NB_DATA +: NB_DATA];
      end
   end

   // rd_word is built from pre-edge contents, giving read-before-write on overlap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         bus.o_r_data <= '0;
      else if (bus.i_r_en)
         bus.o_r_data <= rd_word;
   end
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver queues the expected read data,
// a monitor compares whenever a read completes.
module tb_data_memory;
   logic        clk;
   logic        rst_n;
   logic [31:0] sb_q[$];
   logic        rd_fire;
   int          n_tests;
   int          n_fail;

   data_memory_if #(.NB_DATA_BUS(32), .NB_ADDRESS(6)) bus ();

   data_memory #(.NB_DATA_BUS(32), .NB_DATA(8), .NB_ADDRESS(6)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A read enabled at a rising edge presents its data before the next falling edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_fire <= 1'b0;
      else        rd_fire <= bus.i_r_en;
   end

   always @(negedge clk) begin
      if (rd_fire) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_unexpected: got %08h, no expectation queued", bus.o_r_data);
         end else begin
            logic [31:0] exp;
            exp = sb_q.pop_front();
            if (bus.o_r_data !== exp) begin
               n_fail++;
               $display("FAIL read_data: got %08h, expected %08h", bus.o_r_data, exp);
            end
         end
      end
   end

   task automatic check_now(input string name, input logic [31:0] exp);
      n_tests++;
      if (bus.o_r_data !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, bus.o_r_data, exp);
      end
   endtask

   task automatic idle();
      bus.i_r_en = 1'b0;
      bus.i_w_en = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
      bus.i_w_addr = a; bus.i_w_addressing = sz; bus.i_w_data = d; bus.i_w_en = 1'b1;
      @(negedge clk);
      idle();
   endtask

   task automatic rd(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] exp);
      bus.i_r_addr = a; bus.i_r_addressing = sz; bus.i_r_en = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      idle();
   endtask

   task automatic wr_rd(input logic [5:0] a, input logic [31:0] d, input logic [31:0] exp);
      bus.i_w_addr = a; bus.i_w_addressing = 2'b00; bus.i_w_data = d; bus.i_w_en = 1'b1;
      bus.i_r_addr = a; bus.i_r_addressing = 2'b00; bus.i_r_en = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      idle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.i_r_addr = '0; bus.i_r_addressing = 2'b00; bus.i_r_en = 1'b0;
      bus.i_w_addr = '0; bus.i_w_addressing = 2'b00; bus.i_w_data = '0; bus.i_w_en = 1'b0;
      repeat (3) @(negedge clk);
      check_now("reset_held", 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      rd(6'd0, 2'b00, 32'h0000_0000);
      wr(6'd0, 2'b00, 32'h0123_ABCD);
      rd(6'd0, 2'b00, 32'h0123_ABCD);
      rd(6'd0, 2'b11, 32'h0000_00CD);
      rd(6'd3, 2'b11, 32'h0000_0001);
      rd(6'd0, 2'b01, 32'h0000_ABCD);
      rd(6'd2, 2'b01, 32'h0000_0123);
      rd(6'd0, 2'b10, 32'h0123_ABCD);

      wr(6'd1, 2'b11, 32'hFFFF_FF55);
      rd(6'd0, 2'b00, 32'h0123_55CD);
      wr(6'd2, 2'b01, 32'h9999_BEEF);
      rd(6'd0, 2'b00, 32'hBEEF_55CD);

      wr(6'd62, 2'b00, 32'hA1B2_C3D4);
      rd(6'd62, 2'b11, 32'h0000_00D4);
      rd(6'd63, 2'b11, 32'h0000_00C3);
      rd(6'd0,  2'b11, 32'h0000_00B2);
      rd(6'd1,  2'b11, 32'h0000_00A1);
      rd(6'd62, 2'b00, 32'hA1B2_C3D4);
      rd(6'd0,  2'b00, 32'hBEEF_A1B2);
      rd(6'd63, 2'b01, 32'h0000_B2C3);

      wr_rd(6'd8, 32'h1111_1111, 32'h0000_0000);
      rd(6'd8, 2'b00, 32'h1111_1111);
      repeat (3) @(negedge clk);
      check_now("hold_r_en_low", 32'h1111_1111);

      // Reset arrives while a write is pending: write must not land, memory cleared.
      bus.i_w_addr = 6'd20; bus.i_w_addressing = 2'b00; bus.i_w_data = 32'hDEAD_BEEF; bus.i_w_en = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_now("reset_async_out", 32'h0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      rd(6'd20, 2'b00, 32'h0000_0000);
      rd(6'd0,  2'b00, 32'h0000_0000);
      rd(6'd8,  2'b00, 32'h0000_0000);

      repeat (4) @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
